// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a FWFT FIFO, one serial bit per baud clock.
// Build with UART_TX_PARITY_EN defined to add the optional parity bit.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_INC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         cnt;
  logic                  pop;

`ifdef UART_TX_PARITY_EN
  logic par;
  logic par_en_q;
`else
  logic unused_cfg;
  assign unused_cfg = PAR_EN ^ PAR_TYP;
`endif

  // Pop is combinational so the head word is latched on the same edge.
  assign pop = !RST && !FIFO_EMPTY &&
               (state == IDLE || state == STOP);
  assign FIFO_RD_INC = pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      shift  <= '0;
      cnt    <= '0;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
      par_en_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE, STOP: begin
          if (pop) begin
            state  <= START;
            shift  <= FIFO_RD_DATA;
            TX_OUT <= 1'b0;
            BUSY   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= (^FIFO_RD_DATA) ^ PAR_TYP;
            par_en_q <= PAR_EN;
`endif
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          TX_OUT <= shift[0];
          BUSY   <= 1'b1;
        end
        DATA: begin
          if (cnt == LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
`else
            state  <= STOP;
            TX_OUT <= 1'b1;
`endif
          end else begin
            shift  <= shift >> 1;
            cnt    <= cnt + 1'b1;
            TX_OUT <= shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a bit-queue line model.
// Parity expectations follow the UART_TX_PARITY_EN build macro.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_cmd = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       rd_inc;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx_out;
  logic       busy;

  logic [7:0] q[$];
  logic       exp_bits[$];
  int         vectors = 0;
  int         errors = 0;

  uart_tx_fifo #(.DATA_WIDTH(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .FIFO_EMPTY   (fifo_empty),
    .FIFO_RD_DATA (rd_data),
    .FIFO_RD_INC  (rd_inc),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .TX_OUT       (tx_out),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic got, logic want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, want, $time);
    end
  endtask

  // Frame on the wire: start, LSB-first data, optional parity, stop.
  task automatic add_frame(logic [7:0] d, logic pe, logic pt);
    int ones;
    ones = $countones(d);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (pe) exp_bits.push_back((ones % 2 == 1) ? !pt : pt);
`else
    if (pe && pt && ones < 0) exp_bits.push_back(1'b0);
`endif
    exp_bits.push_back(1'b1);
  endtask

  task automatic step();
    logic want_pop;
    @(posedge clk);
    #1;
    rst = rst_cmd;
    fifo_empty = (q.size() == 0);
    rd_data = fifo_empty ? 8'h00 : q[0];
    @(negedge clk);
    if (rst) begin
      check("rst_tx", tx_out, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_pop", rd_inc, 1'b0);
      exp_bits.delete();
      return;
    end
    if (exp_bits.size() != 0) begin
      check("tx", tx_out, exp_bits[0]);
      check("busy", busy, 1'b1);
      void'(exp_bits.pop_front());
    end else begin
      check("idle_tx", tx_out, 1'b1);
      check("idle_busy", busy, 1'b0);
    end
    want_pop = !fifo_empty && (exp_bits.size() == 0);
    check("pop", rd_inc, want_pop);
    if (want_pop) begin
      add_frame(q[0], par_en, par_typ);
      void'(q.pop_front());
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pops d, then hits reset asynchronously during data bit nbit.
  task automatic mid_reset(logic [7:0] d, int nbit);
    q.push_back(d);
    run(2 + nbit);
    #2;
    rst_cmd = 1'b1;
    rst = 1'b1;
    #1;
    check("arst_tx", tx_out, 1'b1);
    check("arst_busy", busy, 1'b0);
    exp_bits.delete();
    run(2);
    rst_cmd = 1'b0;
    run(6);
  endtask

  initial begin
    q.push_back(8'hA5);
    run(4);
    rst_cmd = 1'b0;
    run(14);

    par_en = 1'b1;
    par_typ = 1'b0;
    q.push_back(8'h03);
    run(13);
    par_typ = 1'b1;
    q.push_back(8'h03);
    run(13);
    par_typ = 1'b0;
    q.push_back(8'h07);
    run(13);

    par_en = 1'b0;
    q.push_back(8'h55);
    q.push_back(8'hF0);
    run(23);

    q.push_back(8'h81);
    run(5);
    par_en = 1'b1;
    par_typ = 1'b1;
    run(4);
    q.push_back(8'h81);
    run(20);

    par_en = 1'b0;
    mid_reset(8'hFF, 4);
    mid_reset(8'h00, 4);

    for (int i = 0; i < 1500; i++) begin
      if (q.size() < 4 && $urandom_range(0, 3) == 0)
        q.push_back(8'($urandom()));
      if ($urandom_range(0, 7) == 0) par_en = !par_en;
      if ($urandom_range(0, 7) == 0) par_typ = !par_typ;
      step();
    end
    q.delete();
    run(15);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
